// File: rtl/freq_m_pkg.sv
// Shared types, limits and the scale/saturate helper for the multi-channel frequency meter.
package freq_m_pkg;

  typedef enum logic [1:0] {IDLE, ARM, GATE} state_t;

  localparam int unsigned MIN_GATE  = 2;
  localparam int unsigned DEF_N_CH  = 4;
  localparam int unsigned DEF_CNT_W = 32;
  localparam int unsigned MAX_W     = 64;

  typedef struct packed {
    logic             sat;
    logic [MAX_W-1:0] value;
  } shl_res_t;

  // Left shift that clamps to all-ones in the low 'width' bits when any bit spills out.
  function automatic shl_res_t sat_shl(input logic [MAX_W-1:0] count,
                                       input logic [4:0]       shamt,
                                       input int unsigned      width);
    logic [MAX_W+31:0] ext;
    shl_res_t          r;
    ext     = {32'd0, count} << shamt;
    r.sat   = |(ext >> width);
    r.value = r.sat ? ({MAX_W{1'b1}} >> (MAX_W - width)) : ext[MAX_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/freq_m_chan.sv
// One measured channel: synchronizer, rising-edge detect, saturating counter,
// and the scaled result / overflow registers loaded at the end of each window.
module freq_m_chan
  import freq_m_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_base,
  input  logic             rst,
  input  logic             sig,
  input  logic             clr,
  input  logic             cnt_en,
  input  logic             latch,
  input  logic [4:0]       shamt,
  output logic [CNT_W-1:0] result,
  output logic             ovf
);

  localparam int unsigned SPILL_W = MAX_W - CNT_W;

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_det;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       count_nxt;
  shl_res_t               scaled;
  logic [SPILL_W-1:0]     spill;
  logic [CNT_W-1:0]       scaled_lo;

  assign edge_det = sync[SYNC_STAGES-1] & ~prev;

  // The result is taken from count_nxt so an edge in the final gate cycle is included.
  always_comb begin
    count_nxt = count;
    if (edge_det && (count != '1)) count_nxt = count + CNT_W'(1);
    scaled = sat_shl(MAX_W'(count_nxt), shamt, CNT_W);
  end

  assign {spill, scaled_lo} = scaled.value;

  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) begin
      sync   <= '0;
      prev   <= 1'b0;
      count  <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig};
      prev <= sync[SYNC_STAGES-1];
      if (clr)         count <= '0;
      else if (cnt_en) count <= count_nxt;
      if (latch) begin
        result <= scaled_lo;
        ovf    <= scaled.sat | (|spill) | (count_nxt == '1);
      end
    end
  end

endmodule

// File: rtl/freq_m_multi.sv
// Multi-channel frequency meter: shared gate-window FSM driving N_CH channel counters,
// publishing all results together with a one-cycle freq_valid strobe.
module freq_m_multi
  import freq_m_pkg::*;
#(
  parameter int unsigned N_CH        = DEF_N_CH,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_base,
  input  logic                  rst,
  input  logic [N_CH-1:0]       sig_in,
  input  logic [31:0]           freq_base,
  input  logic [4:0]            time_del,
  input  logic                  meas_en,
  output logic [N_CH*CNT_W-1:0] freq_mem,
  output logic                  freq_valid,
  output logic [N_CH-1:0]       ovf,
  output logic                  busy
);

  state_t      state;
  logic [31:0] gate_raw;
  logic [31:0] gate_len;
  logic [31:0] gate_cnt;
  logic [4:0]  shamt;
  logic        clr;
  logic        cnt_en;
  logic        last_gate;
  logic        latch;

  assign gate_raw  = freq_base >> time_del;
  assign clr       = (state == ARM);
  assign cnt_en    = (state == GATE);
  assign last_gate = (gate_cnt == gate_len - 32'd1);
  // An abort on the final gate cycle wins: nothing is published.
  assign latch     = cnt_en & meas_en & last_gate;

  always_ff @(posedge clk_base or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gate_len   <= 32'(MIN_GATE);
      gate_cnt   <= '0;
      shamt      <= '0;
      freq_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (meas_en) state <= ARM;
        end
        ARM: begin
          gate_len <= (gate_raw < MIN_GATE) ? 32'(MIN_GATE) : gate_raw;
          shamt    <= time_del;
          gate_cnt <= '0;
          busy     <= 1'b1;
          state    <= GATE;
        end
        GATE: begin
          if (!meas_en) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (last_gate) begin
            busy       <= 1'b0;
            freq_valid <= 1'b1;
            state      <= ARM;
          end else begin
            gate_cnt <= gate_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    freq_m_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_base(clk_base),
      .rst     (rst),
      .sig     (sig_in[k]),
      .clr     (clr),
      .cnt_en  (cnt_en),
      .latch   (latch),
      .shamt   (shamt),
      .result  (freq_mem[k*CNT_W +: CNT_W]),
      .ovf     (ovf[k])
    );
  end

endmodule
